mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised, multi-cycle memory/peripheral bus controller for the pipelined CPU. It arbitrates the IF-stage instruction port and the MEM-stage data port onto one shared asynchronous SRAM bus, which also carries UART data. It adds configurable SRAM wait states, fixed data-port priority, per-port stall outputs and a UART status register. One instance serves the shared RAM1/UART bus; a second instance with the UART disabled serves the program SRAM.

## Interface
Parameters:
- ADDR_W, 18: SRAM address width; both request ports use this width.
- DATA_W, 16: data width; must be at least 2.
- WAIT_CYC, 1: extra strobe cycles per SRAM/UART access (0–15).
- UART_EN, 1: 1 decodes UART addresses; 0 sends every address to SRAM.
- UART_DATA_ADDR, 'hBF00: UART data register address.
- UART_STAT_ADDR, 'hBF01: UART status register address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction read request, level, held until if_ack.
- if_addr  in  ADDR_W  instruction address.
- if_rdata  out  DATA_W  instruction data, valid with if_ack, held until the next if_ack.
- if_ack  out  1  one-cycle completion pulse.
- stall_if  out  1  if_req & ~if_ack.
- mem_req  in  1  data request, level, held until mem_ack.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data, valid with mem_ack, held until the next mem_ack.
- mem_ack  out  1  one-cycle completion pulse.
- stall_mem  out  1  mem_req & ~mem_ack.
- sram_addr  out  ADDR_W  SRAM address.
- sram_data  inout  DATA_W  shared SRAM/UART data bus.
- sram_oe_n, sram_we_n, sram_en_n  out  1  SRAM strobes, active low.
- data_ready, tbre, tsre  in  1  UART flags.
- rdn, wrn  out  1  UART strobes, active low.

## Operation
- States: IDLE, SRAM_RD, SRAM_WR, UART_RWAIT, UART_RD, UART_WR, UART_TWAIT, ACK.
- IDLE arbitration:
  - mem_req beats if_req. If both are high, the data port is served first and stall_if stays high.
  - An instruction access is always an SRAM read.
- Data-port decode, when UART_EN=1. An address matches a UART register only if it equals the parameter in its low 16 bits and is zero above.
  - Status address, read: go to ACK. mem_rdata = {zeros, data_ready, tbre&tsre}, sampled in IDLE.
  - Status address, write: go to ACK with no side effect.
  - Data address, read: go to UART_RWAIT. Stay there until data_ready=1, then go to UART_RD.
  - Data address, write: go to UART_WR.
  - Any other address: SRAM_RD or SRAM_WR.
- SRAM_RD / SRAM_WR:
  - Strobes: sram_en_n=0, sram_addr=request address, sram_oe_n=0 (read) or sram_we_n=0 (write).
  - Held for WAIT_CYC+1 cycles, counted by a 4-bit counter.
  - Read data is captured on the edge that ends the last strobe cycle.
  - The write bus is driven for the whole state.
- UART_RD: rdn=0 for WAIT_CYC+1 cycles; data captured at the end as in SRAM_RD.
- UART_WR:
  - wrn=0 with the bus driven for WAIT_CYC+1 cycles, then go to UART_TWAIT.
  - UART_TWAIT waits for tbre=1 and tsre=1 in the same cycle, then goes to ACK.
- During any UART state, sram_en_n=1.
- ACK: the served port's ack is 1 for exactly one cycle, then IDLE. A requester that keeps req high after ack starts a new access.
- sram_data is driven only in SRAM_WR and UART_WR; it is high-Z everywhere else.
- At most one of sram_oe_n, sram_we_n, rdn, wrn is low in any cycle.

## Timing
- Reset (async, immediate):
  - State IDLE, counter 0.
  - sram_en_n, sram_oe_n, sram_we_n, rdn, wrn = 1; sram_data high-Z; sram_addr = 0.
  - if_rdata, mem_rdata = 0; if_ack, mem_ack = 0.
  - stall_if and stall_mem still follow their req inputs.
  - Asserting reset mid-access abandons the access; no ack is issued.
- Latency: take the cycle in which req is sampled in IDLE as cycle 0.
  - SRAM access: strobes in cycles 1 to WAIT_CYC+1, ack in cycle WAIT_CYC+2.
  - Status register: ack in cycle 1.
  - UART read: add the UART_RWAIT residency.
  - UART write: add the UART_TWAIT residency.
- Throughput: one SRAM access per WAIT_CYC+3 cycles (one IDLE cycle between accesses).
- Inputs are sampled only in IDLE. Address and data changes during an access are ignored; the outputs use registered copies.
- The UART flag inputs are treated as synchronous to clk.

## Test plan
- WAIT_CYC=1, mem write 0x1234 to 0x00010, then mem read 0x00010:
  - sram_we_n low for exactly 2 cycles; mem_ack in cycle 3.
  - Read returns 0x1234, with sram_oe_n low for 2 cycles.
- if_req and mem_req raised in the same cycle:
  - mem access completes first; stall_if stays high through it.
  - if_ack follows WAIT_CYC+3 cycles after mem_ack.
- mem read 0xBF01 with data_ready=1, tbre=1, tsre=0: mem_rdata=0x0002, mem_ack in cycle 1, no strobe toggles.
- mem write 0x0041 to 0xBF00, tsre held low for 5 cycles:
  - wrn low for WAIT_CYC+1 cycles.
  - mem_ack exactly 1 cycle after tbre=tsre=1.
- mem read 0xBF00 with data_ready=0 for 4 cycles, then 1: rdn stays high until data_ready=1; the returned bus value appears on mem_rdata.
- rst pulsed during SRAM_WR, and UART_EN=0 with an access to 0xBF00:
  - Reset: all strobes high and bus high-Z at once; no ack.
  - UART_EN=0: the 0xBF00 access goes to SRAM (sram_en_n=0).

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared SRAM/UART bus controller; the data port always wins over the instruction port.
// SRAM access acks WAIT_CYC+2 cycles after the request is taken; each port stalls until its ack.
module mem_arbiter #(
   parameter int          ADDR_W         = 18,
   parameter int          DATA_W         = 16,
   parameter int          WAIT_CYC       = 1,
   parameter bit          UART_EN        = 1'b1,
   parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
   parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              stall_if,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              stall_mem,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_en_n,
   input  logic              data_ready,
   input  logic              tbre,
   input  logic              tsre,
   output logic              rdn,
   output logic              wrn
);
   typedef enum logic [2:0] {
      IDLE, SRAM_RD, SRAM_WR, UART_RWAIT, UART_RD, UART_WR, UART_TWAIT, ACK
   } state_t;

   localparam logic [3:0]        LAST_CNT = 4'(WAIT_CYC);
   localparam logic [ADDR_W-1:0] DATA_REG = ADDR_W'(UART_DATA_ADDR);
   localparam logic [ADDR_W-1:0] STAT_REG = ADDR_W'(UART_STAT_ADDR);

   state_t            state;
   logic [3:0]        cnt;
   logic              served_mem;
   logic              drive;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] stat_word;
   logic              hit_data;
   logic              hit_stat;
   logic              last;

   always_comb begin
      hit_data     = UART_EN && (mem_addr == DATA_REG);
      hit_stat     = UART_EN && (mem_addr == STAT_REG);
      stat_word    = '0;
      stat_word[1] = data_ready;
      stat_word[0] = tbre & tsre;
   end

   assign last      = (cnt == LAST_CNT);
   assign sram_data = drive ? wdata_q : {DATA_W{1'bz}};
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = mem_req & ~mem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         served_mem <= 1'b0;
         drive      <= 1'b0;
         wdata_q    <= '0;
         sram_addr  <= '0;
         sram_en_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         rdn        <= 1'b1;
         wrn        <= 1'b1;
         if_rdata   <= '0;
         mem_rdata  <= '0;
         if_ack     <= 1'b0;
         mem_ack    <= 1'b0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (mem_req) begin
                  served_mem <= 1'b1;
                  if (hit_stat) begin
                     // Status writes are accepted and ignored; only reads update mem_rdata.
                     if (!mem_we) mem_rdata <= stat_word;
                     mem_ack <= 1'b1;
                     state   <= ACK;
                  end else if (hit_data) begin
                     if (mem_we) begin
                        wdata_q <= mem_wdata;
                        drive   <= 1'b1;
                        wrn     <= 1'b0;
                        state   <= UART_WR;
                     end else begin
                        state <= UART_RWAIT;
                     end
                  end else begin
                     sram_addr <= mem_addr;
                     sram_en_n <= 1'b0;
                     if (mem_we) begin
                        wdata_q   <= mem_wdata;
                        drive     <= 1'b1;
                        sram_we_n <= 1'b0;
                        state     <= SRAM_WR;
                     end else begin
                        sram_oe_n <= 1'b0;
                        state     <= SRAM_RD;
                     end
                  end
               end else if (if_req) begin
                  served_mem <= 1'b0;
                  sram_addr  <= if_addr;
                  sram_en_n  <= 1'b0;
                  sram_oe_n  <= 1'b0;
                  state      <= SRAM_RD;
               end
            end
            SRAM_RD, UART_RD: begin
               if (last) begin
                  if (served_mem) begin
                     mem_rdata <= sram_data;
                     mem_ack   <= 1'b1;
                  end else begin
                     if_rdata <= sram_data;
                     if_ack   <= 1'b1;
                  end
                  sram_en_n <= 1'b1;
                  sram_oe_n <= 1'b1;
                  rdn       <= 1'b1;
                  state     <= ACK;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            SRAM_WR: begin
               if (last) begin
                  sram_en_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  drive     <= 1'b0;
                  mem_ack   <= 1'b1;
                  state     <= ACK;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            UART_RWAIT: begin
               if (data_ready) begin
                  rdn   <= 1'b0;
                  state <= UART_RD;
               end
            end
            UART_WR: begin
               if (last) begin
                  wrn   <= 1'b1;
                  drive <= 1'b0;
                  state <= UART_TWAIT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            UART_TWAIT: begin
               if (tbre && tsre) begin
                  mem_ack <= 1'b1;
                  state   <= ACK;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle expected timeline queue plus directed literal checks.
module tb_mem_arbiter;
   localparam int W = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_req, mem_req, mem_we, data_ready, tbre, tsre;
   logic [17:0] if_addr, mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] if_rdata, mem_rdata;
   logic        if_ack, mem_ack, stall_if, stall_mem;
   logic [17:0] sram_addr;
   wire  [15:0] sram_data;
   logic        sram_oe_n, sram_we_n, sram_en_n, rdn, wrn;

   logic        if_req2, mem_req2, mem_we2, flag0;
   logic [17:0] if_addr2, mem_addr2;
   logic [15:0] mem_wdata2;
   logic [15:0] if_rdata2, mem_rdata2;
   logic        if_ack2, mem_ack2, stall_if2, stall_mem2;
   logic [17:0] sram_addr2;
   wire  [15:0] sram_data2;
   logic        sram_oe_n2, sram_we_n2, sram_en_n2, rdn2, wrn2;

   mem_arbiter #(.WAIT_CYC(W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .stall_if(stall_if),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_mem(stall_mem),
      .sram_addr(sram_addr), .sram_data(sram_data), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_en_n(sram_en_n), .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn)
   );

   mem_arbiter #(.WAIT_CYC(0), .UART_EN(1'b0)) dut2 (
      .clk(clk), .rst(rst),
      .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ack(if_ack2), .stall_if(stall_if2),
      .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .stall_mem(stall_mem2),
      .sram_addr(sram_addr2), .sram_data(sram_data2), .sram_oe_n(sram_oe_n2), .sram_we_n(sram_we_n2),
      .sram_en_n(sram_en_n2), .data_ready(flag0), .tbre(flag0), .tsre(flag0), .rdn(rdn2), .wrn(wrn2)
   );

   // Environment: SRAM and UART receive register answering the strobes
   logic [15:0] sram_mem [0:255];
   logic [15:0] uart_rx;
   logic [15:0] rd_val;
   assign rd_val    = !rdn ? uart_rx : sram_mem[sram_addr[7:0]];
   assign sram_data = (!sram_oe_n || !rdn) ? rd_val : 16'bz;
   always @(negedge clk) if (!sram_en_n && !sram_we_n) sram_mem[sram_addr[7:0]] <= sram_data;

   int we_lo = 0, oe_lo = 0, rd_lo = 0, wr_lo = 0;
   always @(negedge clk) begin
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (!rdn) rd_lo++;
      if (!wrn) wr_lo++;
   end

   int n_checks = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for one cycle
   typedef struct {
      logic en_n, oe_n, we_n, rdn, wrn, iack, mack;
      logic bus_chk; logic [15:0] bus;
      logic addr_chk; logic [17:0] addr;
      logic upd; logic [15:0] rdat;
   } exp_t;

   exp_t q[$];
   logic [15:0] model [0:255];
   logic [15:0] exp_if_rd = '0, exp_mem_rd = '0;

   function automatic exp_t idle_rec();
      exp_t e;
      e.en_n = 1; e.oe_n = 1; e.we_n = 1; e.rdn = 1; e.wrn = 1; e.iack = 0; e.mack = 0;
      e.bus_chk = 0; e.bus = '0; e.addr_chk = 0; e.addr = '0; e.upd = 0; e.rdat = '0;
      return e;
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         e = (q.size() > 0) ? q.pop_front() : idle_rec();
         if (rst) begin
            exp_if_rd  = '0;
            exp_mem_rd = '0;
         end
         if (e.iack && e.upd) exp_if_rd = e.rdat;
         if (e.mack && e.upd) exp_mem_rd = e.rdat;
         chk("sram_en_n", sram_en_n, e.en_n);
         chk("sram_oe_n", sram_oe_n, e.oe_n);
         chk("sram_we_n", sram_we_n, e.we_n);
         chk("rdn", rdn, e.rdn);
         chk("wrn", wrn, e.wrn);
         chk("if_ack", if_ack, e.iack);
         chk("mem_ack", mem_ack, e.mack);
         chk("stall_if", stall_if, if_req & ~e.iack);
         chk("stall_mem", stall_mem, mem_req & ~e.mack);
         chk("if_rdata", if_rdata, exp_if_rd);
         chk("mem_rdata", mem_rdata, exp_mem_rd);
         if (e.bus_chk) chk("bus_wdata", sram_data, e.bus);
         if (e.addr_chk) chk("sram_addr", sram_addr, e.addr);
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   // Strobe cycles plus ack cycle of one SRAM access, from the transaction-level memory model
   task automatic push_sram(input bit is_mem, input bit we, input logic [17:0] a, input logic [15:0] wd);
      exp_t e;
      for (int i = 0; i <= W; i++) begin
         e = idle_rec();
         e.en_n = 0; e.addr_chk = 1; e.addr = a;
         if (we) begin e.we_n = 0; e.bus_chk = 1; e.bus = wd; end
         else e.oe_n = 0;
         q.push_back(e);
      end
      e = idle_rec();
      if (is_mem) e.mack = 1; else e.iack = 1;
      if (we) model[a[7:0]] = wd;
      else begin e.upd = 1; e.rdat = model[a[7:0]]; end
      q.push_back(e);
   endtask

   task automatic mem_op(input bit we, input logic [17:0] a, input logic [15:0] wd);
      mem_req = 1; mem_we = we; mem_addr = a; mem_wdata = wd;
      q.push_back(idle_rec());
      push_sram(1, we, a, wd);
      step(1);
      mem_addr = ~a; mem_wdata = ~wd;   // must be ignored mid-access
      step(W + 2);
      mem_req = 0; mem_we = 0;
   endtask

   initial begin
      exp_t e;
      int s0, s1;
      if_req = 0; mem_req = 0; mem_we = 0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
      data_ready = 0; tbre = 1; tsre = 1; uart_rx = 16'h00C3;
      if_req2 = 0; mem_req2 = 0; mem_we2 = 0; if_addr2 = '0; mem_addr2 = '0; mem_wdata2 = '0; flag0 = 0;
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = 16'hA500 | 16'(i);
         model[i]    = 16'hA500 | 16'(i);
      end

      // Reset state
      step(2);
      if_req = 1;
      #1;
      chk("rst_en_n", sram_en_n, 1); chk("rst_oe_n", sram_oe_n, 1); chk("rst_we_n", sram_we_n, 1);
      chk("rst_rdn", rdn, 1); chk("rst_wrn", wrn, 1); chk("rst_addr", sram_addr, 0);
      chk("rst_if_rdata", if_rdata, 0); chk("rst_mem_rdata", mem_rdata, 0);
      chk("rst_acks", {if_ack, mem_ack}, 0); chk("rst_stall_if", stall_if, 1);
      chk("rst_stall_mem", stall_mem, 0); chk("rst_en_n2", sram_en_n2, 1);
      if_req = 0; rst = 0;
      step(1);

      // SRAM write then read back
      s0 = we_lo;
      mem_op(1, 18'h00010, 16'h1234);
      chk("we_low_cycles", we_lo - s0, 2);
      s0 = oe_lo;
      mem_op(0, 18'h00010, 16'h0000);
      chk("oe_low_cycles", oe_lo - s0, 2);
      chk("lit_rd_1234", mem_rdata, 16'h1234);

      // Simultaneous requests: data port first, instruction port W+3 cycles later
      if_req = 1; if_addr = 18'h00020;
      mem_req = 1; mem_we = 0; mem_addr = 18'h00010;
      q.push_back(idle_rec());
      push_sram(1, 0, 18'h00010, 16'h0);
      q.push_back(idle_rec());
      push_sram(0, 0, 18'h00020, 16'h0);
      step(W + 3); mem_req = 0;
      step(W + 3); if_req = 0;
      chk("lit_if_rd", if_rdata, 16'hA520);
      chk("lit_mem_rd", mem_rdata, 16'h1234);

      // Status register read and write
      data_ready = 1; tbre = 1; tsre = 0;
      s0 = oe_lo + rd_lo + we_lo + wr_lo;
      mem_req = 1; mem_we = 0; mem_addr = 18'h0BF01;
      q.push_back(idle_rec());
      e = idle_rec(); e.mack = 1; e.upd = 1; e.rdat = {14'b0, data_ready, tbre & tsre}; q.push_back(e);
      step(2); mem_req = 0;
      chk("lit_status", mem_rdata, 16'h0002);
      mem_req = 1; mem_we = 1; mem_wdata = 16'hFFFF;
      q.push_back(idle_rec());
      e = idle_rec(); e.mack = 1; q.push_back(e);
      step(2); mem_req = 0; mem_we = 0;
      chk("status_no_strobes", oe_lo + rd_lo + we_lo + wr_lo - s0, 0);

      // UART write, transmitter busy for 5 cycles
      s0 = wr_lo;
      tbre = 1; tsre = 0;
      mem_req = 1; mem_we = 1; mem_addr = 18'h0BF00; mem_wdata = 16'h0041;
      q.push_back(idle_rec());
      for (int i = 0; i <= W; i++) begin
         e = idle_rec(); e.wrn = 0; e.bus_chk = 1; e.bus = 16'h0041; q.push_back(e);
      end
      for (int i = 0; i < 5 - (W + 1); i++) q.push_back(idle_rec());
      e = idle_rec(); e.mack = 1; q.push_back(e);
      step(5); tsre = 1;
      step(2); mem_req = 0; mem_we = 0;
      chk("wrn_low_cycles", wr_lo - s0, W + 1);

      // UART read, receiver empty for 4 cycles
      s0 = rd_lo;
      data_ready = 0;
      mem_req = 1; mem_we = 0; mem_addr = 18'h0BF00;
      for (int i = 0; i < 5; i++) q.push_back(idle_rec());
      for (int i = 0; i <= W; i++) begin
         e = idle_rec(); e.rdn = 0; q.push_back(e);
      end
      e = idle_rec(); e.mack = 1; e.upd = 1; e.rdat = uart_rx; q.push_back(e);
      step(4); data_ready = 1;
      step(W + 3); mem_req = 0;
      chk("rdn_low_cycles", rd_lo - s0, W + 1);
      chk("lit_uart_rd", mem_rdata, 16'h00C3);

      // Reset in the middle of an SRAM write: access abandoned
      mem_req = 1; mem_we = 1; mem_addr = 18'h00030; mem_wdata = 16'hBEEF;
      q.push_back(idle_rec());
      step(1);
      chk("pre_rst_we_n", sram_we_n, 0);
      rst = 1;
      #1;
      chk("arst_en_n", sram_en_n, 1); chk("arst_we_n", sram_we_n, 1);
      chk("arst_oe_n", sram_oe_n, 1); chk("arst_uart", {rdn, wrn}, 2'b11);
      chk("arst_ack", mem_ack, 0); chk("arst_rdata", mem_rdata, 0);
      chk("arst_stall_mem", stall_mem, 1);
      mem_req = 0; mem_we = 0;
      step(1); rst = 0;
      step(2);
      mem_op(0, 18'h00030, 16'h0000);
      chk("lit_abandoned_wr", mem_rdata, 16'hA530);

      // UART disabled: 0xBF00 is an ordinary SRAM location
      mem_req2 = 1; mem_we2 = 1; mem_addr2 = 18'h0BF00; mem_wdata2 = 16'h5555;
      step(1);
      chk("u2_en_n", sram_en_n2, 0); chk("u2_we_n", sram_we_n2, 0);
      chk("u2_addr", sram_addr2, 18'h0BF00); chk("u2_bus", sram_data2, 16'h5555);
      chk("u2_wrn", wrn2, 1); chk("u2_ack_early", mem_ack2, 0);
      step(1);
      chk("u2_ack", mem_ack2, 1); chk("u2_en_n_end", sram_en_n2, 1);
      mem_req2 = 0; mem_we2 = 0;
      step(1);
      chk("u2_ack_pulse", mem_ack2, 0);

      step(3);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
